// File: rtl/hfifo_pkg.sv
// Shared definitions for the hfifo family: width helper and output-stage modes.
package hfifo_pkg;

   localparam int OUT_COMB = 0;
   localparam int OUT_REGD = 1;

   // Ceiling log2, usable in constant expressions; callers pass n >= 2.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/hfifo_ram.sv
// Storage array: DEPTH x DWIDTH, synchronous write, asynchronous read.
module hfifo_ram
   import hfifo_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 256
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [clog2(DEPTH)-1:0]   waddr,
   input  logic [DWIDTH-1:0]         wdata,
   input  logic [clog2(DEPTH)-1:0]   raddr,
   output logic [DWIDTH-1:0]         rdata
);

   logic [DWIDTH-1:0] mem [DEPTH];

   // Write port; contents are not reset, validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hfifo_flow.sv
// Synchronous FIFO with arbitrary depth, optional registered output stage,
// occupancy/almost flags, flush and sticky overflow/underflow flags.
// All status outputs decode registered state only.
module hfifo_flow
   import hfifo_pkg::*;
#(
   parameter int DWIDTH   = 8,
   parameter int DEPTH    = 256,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int OUT_REG  = OUT_COMB
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        flush,
   input  logic [DWIDTH-1:0]           din,
   input  logic                        push,
   output logic                        not_full,
   output logic [DWIDTH-1:0]           dout,
   output logic                        rdy,
   input  logic                        pop,
   output logic [clog2(DEPTH+1)-1:0]   level,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic                        overflow,
   output logic                        underflow,
   input  logic                        clr_err
);

   localparam int AWIDTH = clog2(DEPTH);
   localparam int CWIDTH = clog2(DEPTH + 1);

   localparam logic [AWIDTH-1:0] PTR_LAST = AWIDTH'(DEPTH - 1);
   localparam logic [CWIDTH-1:0] LVL_FULL = CWIDTH'(DEPTH);
   localparam logic [CWIDTH-1:0] LVL_AF   = CWIDTH'(AF_LEVEL);
   localparam logic [CWIDTH-1:0] LVL_AE   = CWIDTH'(AE_LEVEL);

   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH-1:0] rd_ptr;
   logic [DWIDTH-1:0] ram_q;
   logic              push_acc;
   logic              pop_acc;
   logic              rd_adv;
   logic              rdy_i;
   logic [DWIDTH-1:0] dout_i;
   logic              ram_we;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [AWIDTH-1:0] ptr_next(input logic [AWIDTH-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign not_full     = (level != LVL_FULL);
   assign rdy          = rdy_i;
   assign dout         = dout_i;
   assign almost_full  = (level >= LVL_AF);
   assign almost_empty = (level <= LVL_AE);

   assign push_acc = push & not_full;
   assign pop_acc  = pop & rdy_i;
   assign ram_we   = reset_n & ~flush & push_acc;

   hfifo_ram #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (ram_q)
   );

   generate
      if (OUT_REG == OUT_REGD) begin : g_oreg
         logic              ov;
         logic [DWIDTH-1:0] oreg;
         logic              arr_ne;
         logic              load;

         // level counts the output register too, so the array holds level - ov.
         assign arr_ne = ((level - CWIDTH'(ov)) != '0);
         assign load   = (~ov | pop_acc) & arr_ne;

         // Output-register valid bit: refills from the array or empties on pop.
         always_ff @(posedge clk) begin
            if (!reset_n || flush) ov <= 1'b0;
            else if (load)         ov <= 1'b1;
            else if (pop_acc)      ov <= 1'b0;
         end

         // Output-register data capture from the array head.
         always_ff @(posedge clk) begin
            if (load) oreg <= ram_q;
         end

         assign rdy_i  = ov;
         assign dout_i = oreg;
         assign rd_adv = load;
      end else begin : g_comb
         assign rdy_i  = (level != '0);
         assign dout_i = ram_q;
         assign rd_adv = pop_acc;
      end
   endgenerate

   // Pointers and occupancy; flush drops any same-cycle push/pop.
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_acc) wr_ptr <= ptr_next(wr_ptr);
         if (rd_adv)   rd_ptr <= ptr_next(rd_ptr);
         case ({push_acc, pop_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow  & ~clr_err) | (push & ~not_full & ~flush);
         underflow <= (underflow & ~clr_err) | (pop  & ~rdy_i    & ~flush);
      end
   end

endmodule
